// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with flush-to-bubble and an
// optional two-entry skid buffer that registers ready_o.
module pipe_stage_reg #(
    parameter int              WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter bit              SKID   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       count_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    if (SKID) begin : g_skid
        state_t           state_q, state_d;
        logic [WIDTH-1:0] main_q, main_d;
        logic [WIDTH-1:0] skid_q, skid_d;
        logic             ready_q, ready_d;
        logic             in_xfer, out_xfer;

        assign in_xfer  = valid_i & ready_q;
        assign out_xfer = (state_q != EMPTY) & ready_i;

        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            if (flush_i) begin
                state_d = EMPTY;
                main_d  = BUBBLE;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (in_xfer) begin
                            main_d  = data_i;
                            state_d = ONE;
                        end
                    end
                    ONE: begin
                        if (in_xfer && !out_xfer) begin
                            skid_d  = data_i;
                            state_d = FULL;
                        end else if (in_xfer && out_xfer) begin
                            main_d  = data_i;
                        end else if (out_xfer) begin
                            main_d  = BUBBLE;
                            state_d = EMPTY;
                        end
                    end
                    FULL: begin
                        if (out_xfer) begin
                            main_d  = skid_q;
                            state_d = ONE;
                        end
                    end
                    default: begin
                        state_d = EMPTY;
                        main_d  = BUBBLE;
                    end
                endcase
            end
            // ready_o is registered: it tracks whether the skid entry will be free next cycle
            ready_d = (state_d != FULL);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= EMPTY;
                main_q  <= BUBBLE;
                skid_q  <= BUBBLE;
                ready_q <= 1'b1;
            end else begin
                state_q <= state_d;
                main_q  <= main_d;
                skid_q  <= skid_d;
                ready_q <= ready_d;
            end
        end

        assign valid_o = (state_q != EMPTY);
        assign data_o  = main_q;
        assign ready_o = ready_q;
        assign count_o = state_q;
    end else begin : g_single
        logic             valid_q, valid_d;
        logic [WIDTH-1:0] main_q, main_d;
        logic             ready_c;

        assign ready_c = ready_i | ~valid_q;

        always_comb begin
            valid_d = valid_q;
            main_d  = main_q;
            if (flush_i) begin
                valid_d = 1'b0;
                main_d  = BUBBLE;
            end else if (ready_c) begin
                valid_d = valid_i;
                main_d  = valid_i ? data_i : BUBBLE;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                main_q  <= BUBBLE;
            end else begin
                valid_q <= valid_d;
                main_q  <= main_d;
            end
        end

        assign valid_o = valid_q;
        assign data_o  = main_q;
        assign ready_o = ready_c;
        assign count_o = {1'b0, valid_q};
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector tables for both
// modes, then randomized traffic against a queue-based reference model.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: SKID=1, WIDTH=32, BUBBLE=32'h13
    logic        a_rst, a_flush, a_valid_i, a_ready_i;
    logic        a_valid_o, a_ready_o;
    logic [31:0] a_data_i, a_data_o;
    logic [1:0]  a_count_o;

    // DUT B: SKID=0, WIDTH=8, BUBBLE=8'h00
    logic        b_rst, b_flush, b_valid_i, b_ready_i;
    logic        b_valid_o, b_ready_o;
    logic [7:0]  b_data_i, b_data_o;
    logic [1:0]  b_count_o;

    pipe_stage_reg #(.WIDTH(32), .BUBBLE(32'h13), .SKID(1'b1)) dut_a (
        .clk(clk), .rst(a_rst), .flush_i(a_flush),
        .valid_i(a_valid_i), .ready_o(a_ready_o), .data_i(a_data_i),
        .valid_o(a_valid_o), .ready_i(a_ready_i), .data_o(a_data_o),
        .count_o(a_count_o)
    );

    pipe_stage_reg #(.WIDTH(8), .BUBBLE(8'h00), .SKID(1'b0)) dut_b (
        .clk(clk), .rst(b_rst), .flush_i(b_flush),
        .valid_i(b_valid_i), .ready_o(b_ready_o), .data_i(b_data_i),
        .valid_o(b_valid_o), .ready_i(b_ready_i), .data_o(b_data_o),
        .count_o(b_count_o)
    );

    typedef struct {
        logic        rst;
        logic        flush;
        logic        valid;
        logic        ready;
        logic [31:0] data;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_ready;
        logic [1:0]  exp_count;
    } vec_t;

    int tests_run    = 0;
    int tests_failed = 0;

    vec_t tab_a[$];
    vec_t tab_b[$];

    logic [31:0] qa[$];
    logic [7:0]  qb[$];

    function automatic vec_t mk(logic rst, logic flush, logic valid, logic ready,
                                logic [31:0] data, logic ev, logic [31:0] ed,
                                logic er, logic [1:0] ec);
        vec_t v;
        v.rst = rst; v.flush = flush; v.valid = valid; v.ready = ready;
        v.data = data; v.exp_valid = ev; v.exp_data = ed;
        v.exp_ready = er; v.exp_count = ec;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input bit sel_b);
        if (!sel_b) begin
            a_rst = v.rst; a_flush = v.flush; a_valid_i = v.valid;
            a_ready_i = v.ready; a_data_i = v.data;
        end else begin
            b_rst = v.rst; b_flush = v.flush; b_valid_i = v.valid;
            b_ready_i = v.ready; b_data_i = v.data[7:0];
        end
    endtask

    task automatic resetBoth();
        @(negedge clk);
        a_rst = 1'b1; a_flush = 1'b0; a_valid_i = 1'b0; a_ready_i = 1'b0; a_data_i = '0;
        b_rst = 1'b1; b_flush = 1'b0; b_valid_i = 1'b0; b_ready_i = 1'b0; b_data_i = '0;
        @(posedge clk);
        @(posedge clk);
    endtask

    task automatic runTable(input bit sel_b);
        int n;
        n = sel_b ? tab_b.size() : tab_a.size();
        for (int i = 0; i < n; i++) begin
            vec_t v;
            v = sel_b ? tab_b[i] : tab_a[i];
            @(negedge clk);
            applyStimulus(v, sel_b);
            #1;
            if (!sel_b) begin
                checkOutput($sformatf("A[%0d].valid_o", i), {31'd0, a_valid_o}, {31'd0, v.exp_valid});
                checkOutput($sformatf("A[%0d].data_o", i),  a_data_o, v.exp_data);
                checkOutput($sformatf("A[%0d].ready_o", i), {31'd0, a_ready_o}, {31'd0, v.exp_ready});
                checkOutput($sformatf("A[%0d].count_o", i), {30'd0, a_count_o}, {30'd0, v.exp_count});
            end else begin
                checkOutput($sformatf("B[%0d].valid_o", i), {31'd0, b_valid_o}, {31'd0, v.exp_valid});
                checkOutput($sformatf("B[%0d].data_o", i),  {24'd0, b_data_o}, {24'd0, v.exp_data[7:0]});
                checkOutput($sformatf("B[%0d].ready_o", i), {31'd0, b_ready_o}, {31'd0, v.exp_ready});
                checkOutput($sformatf("B[%0d].count_o", i), {30'd0, b_count_o}, {30'd0, v.exp_count});
            end
        end
    endtask

    initial begin
        logic        ea_valid, ea_ready, eb_valid, eb_ready;
        logic [31:0] ea_data;
        logic [7:0]  eb_data;

        // Skid mode: stream, stall, flush while full, flush discarding a transfer, rst+flush
        //             rst f  v  r  data      ev ed        er cnt
        tab_a.push_back(mk(0, 0, 1, 1, 32'h100, 0, 32'h13,  1, 0));
        tab_a.push_back(mk(0, 0, 1, 1, 32'h104, 1, 32'h100, 1, 1));
        tab_a.push_back(mk(0, 0, 1, 1, 32'h108, 1, 32'h104, 1, 1));
        tab_a.push_back(mk(0, 0, 0, 1, 32'h0,   1, 32'h108, 1, 1));
        tab_a.push_back(mk(0, 0, 0, 0, 32'h0,   0, 32'h13,  1, 0));
        tab_a.push_back(mk(0, 0, 1, 0, 32'hA,   0, 32'h13,  1, 0));
        tab_a.push_back(mk(0, 0, 1, 0, 32'hB,   1, 32'hA,   1, 1));
        tab_a.push_back(mk(0, 0, 1, 0, 32'hC,   1, 32'hA,   0, 2));
        tab_a.push_back(mk(0, 0, 1, 0, 32'hC,   1, 32'hA,   0, 2));
        tab_a.push_back(mk(0, 0, 1, 1, 32'hC,   1, 32'hA,   0, 2));
        tab_a.push_back(mk(0, 0, 1, 1, 32'hC,   1, 32'hB,   1, 1));
        tab_a.push_back(mk(0, 0, 0, 1, 32'h0,   1, 32'hC,   1, 1));
        tab_a.push_back(mk(0, 0, 0, 1, 32'h0,   0, 32'h13,  1, 0));
        tab_a.push_back(mk(0, 0, 1, 0, 32'hA,   0, 32'h13,  1, 0));
        tab_a.push_back(mk(0, 0, 1, 0, 32'hB,   1, 32'hA,   1, 1));
        tab_a.push_back(mk(0, 1, 1, 0, 32'hD,   1, 32'hA,   0, 2));
        tab_a.push_back(mk(0, 0, 0, 1, 32'h0,   0, 32'h13,  1, 0));
        tab_a.push_back(mk(0, 0, 1, 0, 32'hE,   0, 32'h13,  1, 0));
        tab_a.push_back(mk(0, 1, 1, 1, 32'hF,   1, 32'hE,   1, 1));
        tab_a.push_back(mk(0, 0, 0, 1, 32'h0,   0, 32'h13,  1, 0));
        tab_a.push_back(mk(0, 0, 1, 0, 32'h20,  0, 32'h13,  1, 0));
        tab_a.push_back(mk(0, 0, 1, 0, 32'h24,  1, 32'h20,  1, 1));
        tab_a.push_back(mk(1, 1, 1, 1, 32'h28,  1, 32'h20,  0, 2));
        tab_a.push_back(mk(0, 0, 0, 0, 32'h0,   0, 32'h13,  1, 0));

        // Single-entry mode: combinational ready_o, hold, replace, bubble, flush
        tab_b.push_back(mk(0, 0, 1, 0, 32'h55, 0, 32'h00, 1, 0));
        tab_b.push_back(mk(0, 0, 1, 0, 32'h66, 1, 32'h55, 0, 1));
        tab_b.push_back(mk(0, 0, 1, 0, 32'h66, 1, 32'h55, 0, 1));
        tab_b.push_back(mk(0, 0, 1, 1, 32'h66, 1, 32'h55, 1, 1));
        tab_b.push_back(mk(0, 0, 0, 0, 32'h0,  1, 32'h66, 0, 1));
        tab_b.push_back(mk(0, 0, 0, 1, 32'h0,  1, 32'h66, 1, 1));
        tab_b.push_back(mk(0, 0, 0, 0, 32'h0,  0, 32'h00, 1, 0));
        tab_b.push_back(mk(0, 1, 1, 1, 32'h77, 0, 32'h00, 1, 0));
        tab_b.push_back(mk(0, 0, 0, 0, 32'h0,  0, 32'h00, 1, 0));
        tab_b.push_back(mk(0, 0, 1, 0, 32'h88, 0, 32'h00, 1, 0));
        tab_b.push_back(mk(0, 1, 0, 0, 32'h0,  1, 32'h88, 0, 1));
        tab_b.push_back(mk(0, 0, 0, 0, 32'h0,  0, 32'h00, 1, 0));

        resetBoth();
        runTable(1'b0);
        resetBoth();
        runTable(1'b1);

        // Random traffic on both instances against an ordered-queue model
        resetBoth();
        qa.delete();
        qb.delete();
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            a_rst = 1'b0; b_rst = 1'b0;
            a_valid_i = 1'($urandom_range(0, 1));
            a_ready_i = 1'($urandom_range(0, 1));
            a_data_i  = $urandom;
            a_flush   = ($urandom_range(0, 63) == 0);
            b_valid_i = 1'($urandom_range(0, 1));
            b_ready_i = 1'($urandom_range(0, 1));
            b_data_i  = 8'($urandom_range(0, 255));
            b_flush   = ($urandom_range(0, 63) == 0);

            ea_valid = (qa.size() != 0);
            ea_data  = ea_valid ? qa[0] : 32'h13;
            ea_ready = (qa.size() < 2);
            eb_valid = (qb.size() != 0);
            eb_data  = eb_valid ? qb[0] : 8'h00;
            eb_ready = b_ready_i || (qb.size() == 0);

            #1;
            checkOutput("rndA.valid_o", {31'd0, a_valid_o}, {31'd0, ea_valid});
            checkOutput("rndA.data_o",  a_data_o, ea_data);
            checkOutput("rndA.ready_o", {31'd0, a_ready_o}, {31'd0, ea_ready});
            checkOutput("rndA.count_o", {30'd0, a_count_o}, 32'(qa.size()));
            checkOutput("rndA.count_max", {31'd0, (a_count_o <= 2'd2)}, 32'd1);
            checkOutput("rndB.valid_o", {31'd0, b_valid_o}, {31'd0, eb_valid});
            checkOutput("rndB.data_o",  {24'd0, b_data_o}, {24'd0, eb_data});
            checkOutput("rndB.ready_o", {31'd0, b_ready_o}, {31'd0, eb_ready});
            checkOutput("rndB.count_o", {30'd0, b_count_o}, 32'(qb.size()));
            checkOutput("rndB.count_max", {31'd0, (b_count_o <= 2'd1)}, 32'd1);

            @(posedge clk);
            if (a_flush) begin
                qa.delete();
            end else begin
                if (ea_valid && a_ready_i) void'(qa.pop_front());
                if (a_valid_i && ea_ready) qa.push_back(a_data_i);
            end
            if (b_flush) begin
                qb.delete();
            end else begin
                if (eb_valid && b_ready_i) void'(qb.pop_front());
                if (b_valid_i && eb_ready) qb.push_back(b_data_i);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
